lc3_decode: RTL and testbench
=============================

// Module: lc3_decode
// PURPOSE
//  Decode stage of the LC-3 pipeline; sits directly downstream of the fetch stage.
//  Captures the instruction word from instruction memory and the fetch stage's npc.
//  Registers the instruction with the control bundles for execute (E_Control), writeback
//  (W_Control) and memory access (Mem_Control). Flags opcodes the pipeline does not support.
// PARAMETERS
//  RST_IR   16'h0000  IR value loaded on reset
// PORTS
//  clk            in   1   clock, all state updates on posedge
//  rst            in   1   synchronous, active-high reset
//  enable_decode  in   1   capture strobe from controller; X/Z treated as 0 (=== compare)
//  Instr_dout     in   16  instruction word from instruction memory
//  npc_in         in   16  PC+1 from fetch stage, aligned with Instr_dout
//  IR             out  16  registered instruction
//  npc_out        out  16  registered npc_in
//  E_Control      out  6   {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//  W_Control      out  2   00 aluout, 01 memout, 10 pcout
//  Mem_Control    out  1   1 = indirect access (LDI/STI)
//  illegal        out  1   1 = registered opcode unsupported
// BEHAVIOUR
//  - Reset (rst=1 at posedge): IR=RST_IR, npc_out=0, E_Control=0, W_Control=0,
//    Mem_Control=0, illegal=0. Reset overrides enable_decode.
//  - Capture: if enable_decode===1 at posedge, all outputs update from Instr_dout/npc_in.
//    Latency is 1 cycle. Outputs are purely registered: no combinational path to outputs.
//  - Hold: if enable_decode is 0/X/Z, every output holds its value. There is no auto-clear.
//  - Field fields: alu_control 00 ADD, 01 AND, 10 NOT.
//    pcselect1: 01 offset9, 10 offset6, 11 zero.
//    pcselect2: 1 = npc base, 0 = register base.
//    op2select: 1 = register (IR[5]==0), 0 = imm5 (IR[5]==1).
//  - Decode table (opcode IR[15:12] -> E_Control / W_Control / Mem_Control):
//      ADD 0001: 00_00_0_op2 / 00 / 0
//      AND 0101: 01_00_0_op2 / 00 / 0
//      NOT 1001: 100000 / 00 / 0
//      BR  0000: 000110 / 00 / 0
//      JMP 1100: 001100 / 00 / 0
//      LD  0010: 000110 / 01 / 0
//      LDR 0110: 001000 / 01 / 0
//      LDI 1010: 000110 / 01 / 1
//      LEA 1110: 000110 / 10 / 0
//      ST  0011: 000110 / 00 / 0
//      STR 0111: 001000 / 00 / 0
//      STI 1011: 000110 / 00 / 1
//  - Unsupported opcodes (0100 JSR, 1000 RTI, 1101 reserved, 1111 TRAP):
//    IR and npc_out are captured; E_Control=0, W_Control=0, Mem_Control=0, illegal=1.
//    For all supported opcodes, illegal=0.
//  - The decode table is combinational on Instr_dout and is registered together with IR,
//    so the control outputs always correspond to the current IR.
//  - If enable_decode is high on consecutive cycles, a new instruction is captured every cycle.
//  - Reset mid-stream: the next posedge clears everything, regardless of the prior contents.
// TESTING
//  1. rst=1 for 2 cycles with enable_decode=1, Instr_dout=16'h1042
//     -> IR=0000, npc_out=0, all controls 0, illegal=0.
//  2. Instr_dout=16'h1042 (ADD reg), npc_in=16'h3001, enable_decode=1 for 1 cycle
//     -> next cycle IR=1042, npc_out=3001, E_Control=000001, W_Control=00, Mem_Control=0.
//  3. After test 2, drive Instr_dout=16'h5025 with enable_decode=0, then Z
//     -> outputs still show 1042/3001; then pulse enable=1 -> E_Control=010000.
//  4. Back-to-back captures: A3FF (LDI), then E1FE (LEA), then C1C0 (JMP)
//     -> E/W/Mem = 000110/01/1, then 000110/10/0, then 001100/00/0, one per cycle.
//  5. Instr_dout=16'hF025 (TRAP), enable_decode=1 -> IR=F025, controls 0, illegal=1.
//     Then 16'h6283 (LDR) -> illegal=0, E_Control=001000, W_Control=01.
//  6. Capture 16'h2005, then assert rst in the same cycle as enable_decode=1 with B000
//     -> reset values win, and B000 is not captured.

Source files
------------

// File: rtl/lc3_decode_if.sv
// LC-3 decode stage bus: capture strobe and fetch-side inputs toward the
// decoder, plus the registered instruction and control bundles it returns.
// The master side is the fetch stage and controller; the slave side is the decoder.
interface lc3_decode_if;
    logic        enable_decode;  // capture strobe, only a clean 1 captures
    logic [15:0] instr_dout;     // instruction word from instruction memory
    logic [15:0] npc_in;         // PC+1 from fetch, aligned with instr_dout
    logic [15:0] ir;             // registered instruction
    logic [15:0] npc_out;        // registered npc_in
    logic [5:0]  e_control;      // {alu_control, pcselect1, pcselect2, op2select}
    logic [1:0]  w_control;      // 00 aluout, 01 memout, 10 pcout
    logic        mem_control;    // 1 = indirect access (LDI/STI)
    logic        illegal;        // 1 = registered opcode unsupported

    // Upstream side: drives the strobe and instruction, observes the decode.
    modport master (
        output enable_decode, instr_dout, npc_in,
        input  ir, npc_out, e_control, w_control, mem_control, illegal
    );

    // Decoder side.
    modport slave (
        input  enable_decode, instr_dout, npc_in,
        output ir, npc_out, e_control, w_control, mem_control, illegal
    );
endinterface

// File: rtl/lc3_decode.sv
// LC-3 pipeline decode stage. Captures the fetched instruction and its npc on
// a clean enable_decode strobe and registers them together with the execute,
// writeback and memory control bundles decoded from the same word, so the
// controls always describe the IR currently being presented downstream.
module lc3_decode #(
    parameter logic [15:0] RST_IR = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    lc3_decode_if.slave  dec_if
);

    // LC-3 opcodes, IR[15:12].
    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RSV  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_NOT = 2'b10
    } alu_ctl_e;

    typedef enum logic [1:0] {
        PC1_NONE = 2'b00,
        PC1_OFF9 = 2'b01,
        PC1_OFF6 = 2'b10,
        PC1_ZERO = 2'b11
    } pcsel1_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC  = 2'b10
    } wb_sel_e;

    // Execute bundle in the bit order the execute stage expects.
    typedef struct packed {
        alu_ctl_e alu_control;
        pcsel1_e  pcselect1;
        logic     pcselect2;   // 1 = npc base, 0 = register base
        logic     op2select;   // 1 = register operand, 0 = imm5
    } e_ctrl_t;

    // Everything that is registered on a capture.
    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        e_ctrl_t     e_ctl;
        wb_sel_e     w_ctl;
        logic        mem_ctl;
        logic        illegal;
    } dec_state_t;

    localparam dec_state_t RESET_STATE = '{
        ir:      RST_IR,
        npc:     16'h0000,
        e_ctl:   '{alu_control: ALU_ADD, pcselect1: PC1_NONE,
                   pcselect2: 1'b0, op2select: 1'b0},
        w_ctl:   WB_ALU,
        mem_ctl: 1'b0,
        illegal: 1'b0
    };

    dec_state_t dec_q;
    dec_state_t dec_d;
    opcode_e    opcode;
    logic       capture;

    assign opcode = opcode_e'(dec_if.instr_dout[15:12]);

    // Only a clean 1 captures; X or Z on the strobe must behave like 0.
    assign capture = (dec_if.enable_decode === 1'b1);

    // Decode the incoming instruction word into the next register contents.
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        dec_d         = RESET_STATE;
        dec_d.ir      = dec_if.instr_dout;
        dec_d.npc     = dec_if.npc_in;

        unique case (opcode)
            OP_ADD: begin
                dec_d.e_ctl.alu_control = ALU_ADD;
                dec_d.e_ctl.op2select   = ~dec_if.instr_dout[5];
            end
            OP_AND: begin
                dec_d.e_ctl.alu_control = ALU_AND;
                dec_d.e_ctl.op2select   = ~dec_if.instr_dout[5];
            end
            OP_NOT: begin
                dec_d.e_ctl.alu_control = ALU_NOT;
            end
            OP_BR, OP_ST: begin
                dec_d.e_ctl.pcselect1 = PC1_OFF9;
                dec_d.e_ctl.pcselect2 = 1'b1;
            end
            OP_JMP: begin
                dec_d.e_ctl.pcselect1 = PC1_ZERO;
            end
            OP_LD: begin
                dec_d.e_ctl.pcselect1 = PC1_OFF9;
                dec_d.e_ctl.pcselect2 = 1'b1;
                dec_d.w_ctl           = WB_MEM;
            end
            OP_LDR: begin
                dec_d.e_ctl.pcselect1 = PC1_OFF6;
                dec_d.w_ctl           = WB_MEM;
            end
            OP_STR: begin
                dec_d.e_ctl.pcselect1 = PC1_OFF6;
            end
            OP_LDI: begin
                dec_d.e_ctl.pcselect1 = PC1_OFF9;
                dec_d.e_ctl.pcselect2 = 1'b1;
                dec_d.w_ctl           = WB_MEM;
                dec_d.mem_ctl         = 1'b1;
            end
            OP_STI: begin
                dec_d.e_ctl.pcselect1 = PC1_OFF9;
                dec_d.e_ctl.pcselect2 = 1'b1;
                dec_d.mem_ctl         = 1'b1;
            end
            OP_LEA: begin
                dec_d.e_ctl.pcselect1 = PC1_OFF9;
                dec_d.e_ctl.pcselect2 = 1'b1;
                dec_d.w_ctl           = WB_PC;
            end
            // JSR, RTI, reserved and TRAP: IR and npc still pass through so
            // the fault can be traced, but every control bundle stays zero.
            OP_JSR, OP_RTI, OP_RSV, OP_TRAP: begin
                dec_d.illegal = 1'b1;
            end
            default: begin
                dec_d.illegal = 1'b1;
            end
        endcase
    end

    // Pipeline register: synchronous reset wins, else capture on the strobe, else hold.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples its input before any of them update on this edge.
        if (rst) begin
            dec_q <= RESET_STATE;
        end else if (capture) begin
            dec_q <= dec_d;
        end
    end

    // Outputs come straight from flops; no combinational path from the inputs.
    assign dec_if.ir          = dec_q.ir;
    assign dec_if.npc_out     = dec_q.npc;
    assign dec_if.e_control   = dec_q.e_ctl;
    assign dec_if.w_control   = dec_q.w_ctl;
    assign dec_if.mem_control = dec_q.mem_ctl;
    assign dec_if.illegal     = dec_q.illegal;

endmodule

// File: tb/tb_lc3_decode.sv
// Self-checking bench for lc3_decode: directed scenarios plus a randomized
// run, all compared against a rule-based reference model of the decode table.
module tb_lc3_decode;

    localparam logic [15:0] RST_IR = 16'h0000;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    // Model of the registered outputs: {ir, npc, e, w, mem, illegal}.
    logic [41:0] model_q;

    lc3_decode_if bus ();

    lc3_decode #(.RST_IR(RST_IR)) dut (
        .clk    (clk),
        .rst    (rst),
        .dec_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bits {e[5:0], w[1:0], mem, illegal} derived from opcode groups.
    function automatic logic [9:0] ref_ctl(input logic [15:0] instr);
        int         op;
        logic [1:0] alu;
        logic [1:0] ps1;
        logic       ps2;
        logic       op2;
        logic [1:0] wsel;
        logic       mem;
        op   = int'(instr[15:12]);
        alu  = 2'd0;
        ps1  = 2'd0;
        ps2  = 1'b0;
        op2  = 1'b0;
        wsel = 2'd0;
        mem  = 1'b0;
        // JSR, RTI, reserved, TRAP
        if (op inside {4, 8, 13, 15}) return 10'b00000000_0_1;
        if (op == 5) alu = 2'd1;
        if (op == 9) alu = 2'd2;
        // PC-relative offset9 users: BR LD ST LDI STI LEA
        if (op inside {0, 2, 3, 10, 11, 14}) begin
            ps1 = 2'd1;
            ps2 = 1'b1;
        end
        if (op inside {6, 7}) ps1 = 2'd2;
        if (op == 12) ps1 = 2'd3;
        if (op inside {1, 5}) op2 = ~instr[5];
        if (op inside {2, 6, 10}) wsel = 2'd1;
        if (op == 14) wsel = 2'd2;
        mem = (op inside {10, 11});
        return {alu, ps1, ps2, op2, wsel, mem, 1'b0};
    endfunction

    function automatic logic [41:0] dut_vec();
        return {bus.ir, bus.npc_out, bus.e_control, bus.w_control,
                bus.mem_control, bus.illegal};
    endfunction

    // Apply one clock edge to both the DUT and the model, sample #1 after.
    task automatic tick();
        logic [41:0] nxt;
        nxt = model_q;
        if (rst === 1'b1)
            nxt = {RST_IR, 16'h0000, 10'd0};
        else if (bus.enable_decode === 1'b1)
            nxt = {bus.instr_dout, bus.npc_in, ref_ctl(bus.instr_dout)};
        @(posedge clk);
        #1;
        model_q = nxt;
    endtask

    task automatic drive(input logic en, input logic [15:0] instr, input logic [15:0] npc);
        bus.enable_decode = en;
        bus.instr_dout    = instr;
        bus.npc_in        = npc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 16'h1042, 16'h3001);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (dut_vec() !== {RST_IR, 16'h0000, 10'd0}) begin
                bad++;
                $display("FAIL reset[%0d]: got=%h want=%h", i, dut_vec(), {RST_IR, 16'h0000, 10'd0});
            end
        end
        rst = 1'b0;
        drive(1'b0, 16'h1042, 16'h3001);
    endtask

    task automatic test_capture();
        drive(1'b1, 16'h1042, 16'h3001);
        tick();
        total++;
        if (dut_vec() !== {16'h1042, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL capture_add: got=%h want=%h", dut_vec(),
                     {16'h1042, 16'h3001, 6'b000001, 2'b00, 1'b0, 1'b0});
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 16'h5025, 16'h3002);
        #1;
        total++;
        if (dut_vec() !== model_q) begin
            bad++;
            $display("FAIL no_comb_path: got=%h want=%h", dut_vec(), model_q);
        end
        tick();
        total++;
        if (dut_vec() !== model_q || bus.ir !== 16'h1042) begin
            bad++;
            $display("FAIL hold_en0: got=%h want=%h", dut_vec(), model_q);
        end
        bus.enable_decode = 1'bz;
        tick();
        total++;
        if (dut_vec() !== model_q || bus.npc_out !== 16'h3001) begin
            bad++;
            $display("FAIL hold_enz: got=%h want=%h", dut_vec(), model_q);
        end
        bus.enable_decode = 1'b1;
        tick();
        total++;
        if (bus.e_control !== 6'b010000 || dut_vec() !== model_q) begin
            bad++;
            $display("FAIL capture_and: got e=%b vec=%h want e=010000 vec=%h",
                     bus.e_control, dut_vec(), model_q);
        end
        bus.enable_decode = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] instrs [3];
        logic [8:0]  want   [3];
        instrs = '{16'hA3FF, 16'hE1FE, 16'hC1C0};
        want   = '{9'b000110_01_1, 9'b000110_10_0, 9'b001100_00_0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, instrs[i], 16'h4000 + 16'(i));
            tick();
            total++;
            if ({bus.e_control, bus.w_control, bus.mem_control} !== want[i] ||
                dut_vec() !== model_q) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got ctl=%b vec=%h want ctl=%b vec=%h",
                         i, {bus.e_control, bus.w_control, bus.mem_control}, dut_vec(),
                         want[i], model_q);
            end
        end
        bus.enable_decode = 1'b0;
    endtask

    task automatic test_illegal();
        logic [15:0] seq [6];
        seq = '{16'hF025, 16'h6283, 16'h4ABC, 16'h8000, 16'hD123, 16'h9FFF};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, seq[i], 16'h5000 + 16'(i));
            tick();
            total++;
            if (dut_vec() !== model_q) begin
                bad++;
                $display("FAIL illegal_seq[%0d]: got=%h want=%h", i, dut_vec(), model_q);
            end
            if (i == 0) begin
                total++;
                if (bus.ir !== 16'hF025 || bus.illegal !== 1'b1 || bus.e_control !== 6'd0) begin
                    bad++;
                    $display("FAIL trap: got ir=%h ill=%b e=%b want ir=f025 ill=1 e=000000",
                             bus.ir, bus.illegal, bus.e_control);
                end
            end
            if (i == 1) begin
                total++;
                if (bus.illegal !== 1'b0 || bus.e_control !== 6'b001000 || bus.w_control !== 2'b01) begin
                    bad++;
                    $display("FAIL ldr_after_trap: got ill=%b e=%b w=%b want ill=0 e=001000 w=01",
                             bus.illegal, bus.e_control, bus.w_control);
                end
            end
        end
        bus.enable_decode = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 16'h2005, 16'h6000);
        tick();
        total++;
        if (dut_vec() !== model_q) begin
            bad++;
            $display("FAIL ld_capture: got=%h want=%h", dut_vec(), model_q);
        end
        rst = 1'b1;
        drive(1'b1, 16'hB000, 16'h6001);
        tick();
        rst = 1'b0;
        bus.enable_decode = 1'b0;
        total++;
        if (dut_vec() !== {RST_IR, 16'h0000, 10'd0}) begin
            bad++;
            $display("FAIL reset_mid: got=%h want=%h", dut_vec(), {RST_IR, 16'h0000, 10'd0});
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       bus.enable_decode = 1'b0;
                1:       bus.enable_decode = 1'bz;
                default: bus.enable_decode = 1'b1;
            endcase
            bus.instr_dout = 16'($urandom);
            bus.npc_in     = 16'($urandom);
            tick();
            total++;
            if (dut_vec() !== model_q) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: got=%h want=%h", i, dut_vec(), model_q);
            end
        end
        rst = 1'b0;
        bus.enable_decode = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        model_q = '0;
        rst     = 1'b1;
        drive(1'b0, 16'h0000, 16'h0000);
        test_reset();
        test_capture();
        test_hold();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
